// File: rtl/ram_be_pipe_pkg.sv
// Shared definitions for the ram_be_pipe storage RAM.
//   RDW_OLD / RDW_NEW : encodings of the RDW_MODE parameter
//   clr_state_t       : states of the optional post-reset clear engine
//   num_bytes()       : number of byte lanes in a data word
package ram_be_pipe_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLEAR,
    RUN
  } clr_state_t;

  function automatic int num_bytes(input int dwidth, input int byte_w);
    return dwidth / byte_w;
  endfunction

endpackage

// File: rtl/ram_be_pipe_clear.sv
// Post-reset zero-clear engine for ram_be_pipe. After reset it sweeps every
// address once, one per cycle, then raises ready_o and stays in RUN.
// Ports:
//   clk_i          clock, rising edge
//   srst_i         synchronous active-high reset; restarts the sweep at 0
//   clear_wr_en_o  write the all-zero word to clear_addr_o this cycle
//   clear_addr_o   address being cleared
//   ready_o        high once the sweep has completed
module ram_be_pipe_clear
  import ram_be_pipe_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  output logic              clear_wr_en_o,
  output logic [AWIDTH-1:0] clear_addr_o,
  output logic              ready_o
);

  clr_state_t        state_q;
  logic [AWIDTH-1:0] cnt_q;
  logic              ready_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Gated by srst_i so a reset edge never writes a stale counter address.
  assign clear_wr_en_o = (state_q == CLEAR) && !srst_i;
  assign clear_addr_o  = cnt_q;
  assign ready_o       = ready_q;

endmodule

// File: rtl/ram_be_pipe.sv
// Simple dual-port synchronous RAM with per-byte write enables, read latency
// of 1 or 2 cycles with a read-valid flag, and selectable same-address
// read-during-write result (old word or byte-merged new word).
// Optional: define RAM_BE_PIPE_CLEAR_EN to zero the whole array after every
// reset; ready_o is low while the sweep runs. Without it ready_o is tied high.
// Ports:
//   clk_i      clock, rising edge
//   srst_i     synchronous active-high reset (read pipeline only)
//   wr_en_i    write request        wr_addr_i  write address
//   wr_data_i  write data           wr_be_i    per-lane write enables
//   rd_en_i    read request         rd_addr_i  read address
//   rd_data_o  read data            rd_valid_o new read result this cycle
//   ready_o    RAM accepts reads and writes
module ram_be_pipe
  import ram_be_pipe_pkg::*;
#(
  parameter  int DWIDTH     = 32,
  parameter  int AWIDTH     = 8,
  parameter  int BYTE_W     = 8,
  parameter  int RD_LATENCY = 1,
  parameter  int RDW_MODE   = RDW_OLD,
  localparam int NUM_BYTES  = num_bytes(DWIDTH, BYTE_W)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 wr_en_i,
  input  logic [AWIDTH-1:0]    wr_addr_i,
  input  logic [DWIDTH-1:0]    wr_data_i,
  input  logic [NUM_BYTES-1:0] wr_be_i,
  input  logic                 rd_en_i,
  input  logic [AWIDTH-1:0]    rd_addr_i,
  output logic [DWIDTH-1:0]    rd_data_o,
  output logic                 rd_valid_o,
  output logic                 ready_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("ram_be_pipe: RD_LATENCY must be 1 or 2");
  end
  if ((DWIDTH % BYTE_W) != 0) begin : g_bad_width
    $error("ram_be_pipe: DWIDTH must be a multiple of BYTE_W");
  end

  logic                 ready;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 mem_we;
  logic [AWIDTH-1:0]    mem_waddr;
  logic [DWIDTH-1:0]    mem_wdata;
  logic [NUM_BYTES-1:0] mem_be;
  logic [DWIDTH-1:0]    mem_q [DEPTH];
  logic [DWIDTH-1:0]    rd_word_d;
  logic [DWIDTH-1:0]    rd_data_q;
  logic                 rd_valid_q;

  assign wr_fire = wr_en_i && ready && !srst_i;
  assign rd_fire = rd_en_i && ready && !srst_i;

`ifdef RAM_BE_PIPE_CLEAR_EN
  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;

  ram_be_pipe_clear #(
    .AWIDTH(AWIDTH)
  ) u_clear (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .clear_wr_en_o(clr_we),
    .clear_addr_o (clr_addr),
    .ready_o      (ready)
  );

  // User writes are blocked by ready=0, so the clear engine owns the port
  // whenever clr_we is high.
  assign mem_we    = clr_we || wr_fire;
  assign mem_waddr = clr_we ? clr_addr : wr_addr_i;
  assign mem_wdata = clr_we ? '0 : wr_data_i;
  assign mem_be    = clr_we ? '1 : wr_be_i;
`else
  assign ready     = 1'b1;
  assign mem_we    = wr_fire;
  assign mem_waddr = wr_addr_i;
  assign mem_wdata = wr_data_i;
  assign mem_be    = wr_be_i;
`endif

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (mem_we && mem_be[k]) begin
        mem_q[mem_waddr][k*BYTE_W +: BYTE_W] <= mem_wdata[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Array read plus optional same-edge bypass of the enabled write lanes.
  always_comb begin
    rd_word_d = mem_q[rd_addr_i];
    if ((RDW_MODE == RDW_NEW) && wr_fire && (wr_addr_i == rd_addr_i)) begin
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
        if (wr_be_i[k]) begin
          rd_word_d[k*BYTE_W +: BYTE_W] = wr_data_i[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DWIDTH-1:0] stage_q;
    logic              stage_vld_q;

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        stage_q     <= '0;
        stage_vld_q <= 1'b0;
        rd_data_q   <= '0;
        rd_valid_q  <= 1'b0;
      end else begin
        stage_vld_q <= rd_fire;
        if (rd_fire) begin
          stage_q <= rd_word_d;
        end
        rd_valid_q <= stage_vld_q;
        if (stage_vld_q) begin
          rd_data_q <= stage_q;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_fire;
        if (rd_fire) begin
          rd_data_q <= rd_word_d;
        end
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ready_o    = ready;

endmodule

// File: tb/tb_ram_be_pipe.sv
// Directed bench for ram_be_pipe. Three instances share one stimulus:
//   u_l1o : RD_LATENCY=1, RDW_MODE=0
//   u_l2o : RD_LATENCY=2, RDW_MODE=0
//   u_l1n : RD_LATENCY=1, RDW_MODE=1
// With RAM_BE_PIPE_CLEAR_EN defined, a fourth AWIDTH=4 instance covers the
// clear engine.
module tb_ram_be_pipe;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;

  logic [31:0] d_l1o, d_l2o, d_l1n;
  logic        v_l1o, v_l2o, v_l1n;
  logic        r_l1o, r_l2o, r_l1n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_be_pipe #(.DWIDTH(32), .AWIDTH(8), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0)) u_l1o (
    .clk_i(clk), .srst_i(srst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(d_l1o),
    .rd_valid_o(v_l1o), .ready_o(r_l1o));

  ram_be_pipe #(.DWIDTH(32), .AWIDTH(8), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(0)) u_l2o (
    .clk_i(clk), .srst_i(srst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(d_l2o),
    .rd_valid_o(v_l2o), .ready_o(r_l2o));

  ram_be_pipe #(.DWIDTH(32), .AWIDTH(8), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(1)) u_l1n (
    .clk_i(clk), .srst_i(srst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(d_l1n),
    .rd_valid_o(v_l1n), .ready_o(r_l1n));

`ifdef RAM_BE_PIPE_CLEAR_EN
  logic [31:0] d_clr;
  logic        v_clr, r_clr;

  ram_be_pipe #(.DWIDTH(32), .AWIDTH(4), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0)) u_clr (
    .clk_i(clk), .srst_i(srst), .wr_en_i(wr_en), .wr_addr_i(wr_addr[3:0]), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr[3:0]), .rd_data_o(d_clr),
    .rd_valid_o(v_clr), .ready_o(r_clr));
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Waits (bounded) for the big instances to leave their clear sweep.
  task automatic wait_ready();
`ifdef RAM_BE_PIPE_CLEAR_EN
    for (int i = 0; i < 400; i++) begin
      if (r_l1o && r_l2o && r_l1n) break;
      tick();
    end
    checks++;
    if (!(r_l1o && r_l2o && r_l1n)) begin
      failures++;
      $display("FAIL wait_ready timeout got=%b%b%b exp=111", r_l1o, r_l2o, r_l1n);
    end
`endif
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick(); tick();
    checks++; if (v_l1o !== 1'b0) begin failures++; $display("FAIL reset_valid_l1o got=%b exp=0", v_l1o); end
    checks++; if (v_l2o !== 1'b0) begin failures++; $display("FAIL reset_valid_l2o got=%b exp=0", v_l2o); end
    checks++; if (v_l1n !== 1'b0) begin failures++; $display("FAIL reset_valid_l1n got=%b exp=0", v_l1n); end
    checks++; if (d_l1o !== 32'h0) begin failures++; $display("FAIL reset_data_l1o got=%h exp=0", d_l1o); end
    checks++; if (d_l2o !== 32'h0) begin failures++; $display("FAIL reset_data_l2o got=%h exp=0", d_l2o); end
    checks++; if (d_l1n !== 32'h0) begin failures++; $display("FAIL reset_data_l1n got=%h exp=0", d_l1n); end
`ifdef RAM_BE_PIPE_CLEAR_EN
    checks++; if (r_l1o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", r_l1o); end
`else
    checks++;
    if ({r_l1o, r_l2o, r_l1n} !== 3'b111) begin
      failures++; $display("FAIL reset_ready got=%b%b%b exp=111", r_l1o, r_l2o, r_l1n);
    end
`endif
    srst = 1'b0;
    wait_ready();
  endtask

  task automatic test_byte_enable();
    do_write(8'd5, 32'hAABBCCDD, 4'b1111);
    do_write(8'd5, 32'h11223344, 4'b0101);
    checks++; if (v_l1o !== 1'b0) begin failures++; $display("FAIL be_idle_valid got=%b exp=0", v_l1o); end
    rd_en = 1'b1; rd_addr = 8'd5;
    tick();
    rd_en = 1'b0;
    checks++; if (v_l1o !== 1'b1) begin failures++; $display("FAIL be_valid got=%b exp=1", v_l1o); end
    checks++; if (d_l1o !== 32'hAA22CC44) begin failures++; $display("FAIL be_merge got=%h exp=aa22cc44", d_l1o); end
    tick();
    checks++; if (v_l1o !== 1'b0) begin failures++; $display("FAIL be_valid_drop got=%b exp=0", v_l1o); end
    checks++; if (d_l1o !== 32'hAA22CC44) begin failures++; $display("FAIL be_hold got=%h exp=aa22cc44", d_l1o); end
    // All lanes disabled: legal no-op.
    do_write(8'd5, 32'h00000000, 4'b0000);
    rd_en = 1'b1; rd_addr = 8'd5;
    tick();
    rd_en = 1'b0;
    checks++; if (d_l1o !== 32'hAA22CC44) begin failures++; $display("FAIL be_noop got=%h exp=aa22cc44", d_l1o); end
    // Top address, full word.
    do_write(8'hFF, 32'h5A5AA5A5, 4'b1111);
    rd_en = 1'b1; rd_addr = 8'hFF;
    tick();
    rd_en = 1'b0;
    checks++; if (d_l1o !== 32'h5A5AA5A5) begin failures++; $display("FAIL be_top_addr got=%h exp=5a5aa5a5", d_l1o); end
  endtask

  task automatic test_back_to_back();
    do_write(8'd0, 32'h10, 4'b1111);
    do_write(8'd1, 32'h11, 4'b1111);
    do_write(8'd2, 32'h12, 4'b1111);
    rd_en = 1'b1; rd_addr = 8'd0;
    tick();
    checks++; if (v_l2o !== 1'b0) begin failures++; $display("FAIL b2b_lat2_early got=%b exp=0", v_l2o); end
    checks++; if (d_l1o !== 32'h10) begin failures++; $display("FAIL b2b_lat1_d0 got=%h exp=10", d_l1o); end
    rd_addr = 8'd1;
    tick();
    checks++; if ({v_l2o, d_l2o} !== {1'b1, 32'h10}) begin failures++; $display("FAIL b2b_r0 got=%b/%h exp=1/10", v_l2o, d_l2o); end
    rd_addr = 8'd2;
    tick();
    checks++; if ({v_l2o, d_l2o} !== {1'b1, 32'h11}) begin failures++; $display("FAIL b2b_r1 got=%b/%h exp=1/11", v_l2o, d_l2o); end
    rd_en = 1'b0;
    tick();
    checks++; if ({v_l2o, d_l2o} !== {1'b1, 32'h12}) begin failures++; $display("FAIL b2b_r2 got=%b/%h exp=1/12", v_l2o, d_l2o); end
    tick();
    checks++; if ({v_l2o, d_l2o} !== {1'b0, 32'h12}) begin failures++; $display("FAIL b2b_end got=%b/%h exp=0/12", v_l2o, d_l2o); end
  endtask

  task automatic test_inflight_write();
    rd_en = 1'b1; rd_addr = 8'd1;
    tick();
    rd_en = 1'b0;
    do_write(8'd1, 32'hDEAD0001, 4'b1111);
    checks++; if ({v_l2o, d_l2o} !== {1'b1, 32'h11}) begin failures++; $display("FAIL inflight_old got=%b/%h exp=1/11", v_l2o, d_l2o); end
    rd_en = 1'b1; rd_addr = 8'd1;
    tick();
    rd_en = 1'b0;
    tick();
    checks++; if ({v_l2o, d_l2o} !== {1'b1, 32'hDEAD0001}) begin failures++; $display("FAIL inflight_new got=%b/%h exp=1/dead0001", v_l2o, d_l2o); end
  endtask

  task automatic test_rdw();
    do_write(8'd7, 32'h12345678, 4'b1111);
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'hFFFF0000; wr_be = 4'b1100;
    rd_en = 1'b1; rd_addr = 8'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (d_l1o !== 32'h12345678) begin failures++; $display("FAIL rdw_old got=%h exp=12345678", d_l1o); end
    checks++; if (d_l1n !== 32'hFFFF5678) begin failures++; $display("FAIL rdw_new got=%h exp=ffff5678", d_l1n); end
    tick();
    checks++; if (d_l2o !== 32'h12345678) begin failures++; $display("FAIL rdw_old_lat2 got=%h exp=12345678", d_l2o); end
    // Write elsewhere while reading addr 7: no interaction.
    wr_en = 1'b1; wr_addr = 8'd8; wr_data = 32'hCAFEBABE; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 8'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (d_l1o !== 32'hFFFF5678) begin failures++; $display("FAIL rdw_diff_old got=%h exp=ffff5678", d_l1o); end
    checks++; if (d_l1n !== 32'hFFFF5678) begin failures++; $display("FAIL rdw_diff_new got=%h exp=ffff5678", d_l1n); end
  endtask

  task automatic test_reset_midflight();
    rd_en = 1'b1; rd_addr = 8'd2;
    tick();
    rd_en = 1'b0; srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if ({v_l2o, d_l2o} !== {1'b0, 32'h0}) begin failures++; $display("FAIL midrst_clear got=%b/%h exp=0/0", v_l2o, d_l2o); end
    tick();
    checks++; if (v_l2o !== 1'b0) begin failures++; $display("FAIL midrst_pulse1 got=%b exp=0", v_l2o); end
    tick();
    checks++; if (v_l2o !== 1'b0) begin failures++; $display("FAIL midrst_pulse2 got=%b exp=0", v_l2o); end
    wait_ready();
  endtask

`ifdef RAM_BE_PIPE_CLEAR_EN
  task automatic test_clear();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if (r_clr !== 1'b0) begin failures++; $display("FAIL clr_ready_rst got=%b exp=0", r_clr); end
    for (int i = 1; i <= 16; i++) begin
      if (i == 10) begin
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
        rd_en = 1'b1; rd_addr = 8'd3;
      end
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      checks++;
      if (r_clr !== (i == 16)) begin
        failures++; $display("FAIL clr_ready cycle=%0d got=%b exp=%b", i, r_clr, (i == 16));
      end
      checks++;
      if (v_clr !== 1'b0) begin failures++; $display("FAIL clr_valid cycle=%0d got=%b exp=0", i, v_clr); end
    end
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 8'(a);
      tick();
      rd_en = 1'b0;
      checks++;
      if ({v_clr, d_clr} !== {1'b1, 32'h0}) begin
        failures++; $display("FAIL clr_zero addr=%0d got=%b/%h exp=1/0", a, v_clr, d_clr);
      end
    end
  endtask

  task automatic test_clear_restart();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (r_clr !== (i == 16)) begin
        failures++; $display("FAIL clr_restart cycle=%0d got=%b exp=%b", i, r_clr, (i == 16));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef RAM_BE_PIPE_CLEAR_EN
    test_clear();
    test_clear_restart();
    wait_ready();
`endif
    test_byte_enable();
    test_back_to_back();
    test_inflight_write();
    test_rdw();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_be_pipe.md
Name: ram_be_pipe

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, single clock domain.
- Successor to the basic FIFO storage RAM, adding:
  - per-byte write enables
  - configurable read latency (1 or 2) with a read-valid flag
  - selectable read-during-write behaviour
  - optional post-reset zero-clear engine
- Used as the storage element under FIFOs and packet buffers.

Parameters:
- DWIDTH, 32, data word width; must be a multiple of BYTE_W.
- AWIDTH, 8, address width; depth = 2**AWIDTH words.
- BYTE_W, 8, bits per byte lane; NUM_BYTES = DWIDTH/BYTE_W.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2, anything else is an elaboration error.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (byte-merged).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- srst_i  input  1  synchronous reset, active-high.
- wr_en_i  input  1  write request.
- wr_addr_i  input  AWIDTH  write address.
- wr_data_i  input  DWIDTH  write data.
- wr_be_i  input  NUM_BYTES  byte enables; bit k covers wr_data_i[k*BYTE_W +: BYTE_W].
- rd_en_i  input  1  read request.
- rd_addr_i  input  AWIDTH  read address.
- rd_data_o  output  DWIDTH  read data.
- rd_valid_o  output  1  rd_data_o carries a new read result this cycle.
- ready_o  output  1  RAM accepts reads and writes.

Behaviour:
- Reset (srst_i=1 at an edge):
  - rd_valid_o<=0 and rd_data_o<=0; all read pipeline stages cleared.
  - Write and read requests presented in the same cycle are ignored.
  - Array contents are not reset, except when the optional feature is compiled in.
- Write: on an edge with wr_en_i=1, ready_o=1 and srst_i=0, each lane k with wr_be_i[k]=1 is updated. Other lanes keep their contents. wr_be_i=0 is a legal no-op.
- Read, RD_LATENCY=1:
  - A read accepted at edge N (rd_en_i=1, ready_o=1) drives rd_data_o and rd_valid_o=1 after edge N.
  - If no read is accepted, rd_valid_o=0 and rd_data_o holds its last value.
- Read, RD_LATENCY=2:
  - The array read lands in an internal stage register at edge N.
  - The output register loads from that stage at edge N+1, giving rd_valid_o=1 after N+1.
  - The output register updates only when the stage is valid; otherwise it holds.
  - Back-to-back reads give a result every cycle.
- Read-during-write (same address, same edge):
  - RDW_MODE=0: rd_data_o returns the pre-write word.
  - RDW_MODE=1: per lane, enabled lanes return wr_data_i and disabled lanes return stored data.
  - Different addresses: no interaction.
- Pipeline and wrap-around:
  - In RD_LATENCY=2, a write issued at edge N+1 to an address read at edge N does not alter that in-flight result.
  - Address wrap-around is natural modulo 2**AWIDTH; there are no out-of-range addresses.
- Reset mid-operation: in-flight reads are discarded (no rd_valid_o pulse follows). A write coincident with srst_i does not occur.

Optional Feature:
- Macro: RAM_BE_PIPE_CLEAR_EN.
- With the macro defined:
  - FSM with states CLEAR and RUN. srst_i forces CLEAR with the clear counter at 0.
  - In CLEAR:
    - Writes all-zero words (all lanes) to address counter, one per cycle.
    - ready_o=0.
    - User wr_en_i and rd_en_i are ignored; rd_valid_o stays 0.
  - After writing address 2**AWIDTH-1: go to RUN, ready_o=1 from the next cycle. Clear takes exactly 2**AWIDTH cycles after reset release.
  - srst_i during CLEAR restarts the clear from address 0.
- Without the macro: no FSM or counter; ready_o is constant 1 and the array is uninitialised.

Decomposition:
- Package ram_be_pipe_pkg holds:
  - RDW_OLD/RDW_NEW constants
  - typedef enum logic {CLEAR, RUN} clr_state_t
  - helper function num_bytes(DWIDTH, BYTE_W)
- One sub-module, ram_be_pipe_clear: the clear FSM and counter. Outputs are clear_wr_en, clear_addr and ready. It is instantiated only under the macro.
- Write-port muxing between user and clear engine, and the byte-merge bypass, stay in the top module.

Test Plan:
- Write 0xAABBCCDD to addr 5 with be=4'b1111, then be=4'b0101 with data 0x11223344, then read addr 5 -> 0xAA22CC44, rd_valid_o high exactly one cycle after the read, for RD_LATENCY=1.
- RD_LATENCY=2: reads of addr 0,1,2 on three consecutive cycles (contents 0x10,0x11,0x12) -> rd_valid_o high for three consecutive cycles starting 2 cycles after the first read, data 0x10,0x11,0x12.
- Same-edge write of 0xFFFF0000 (be=4'b1100) and read at addr 7 holding 0x12345678 -> RDW_MODE=0 returns 0x12345678; RDW_MODE=1 returns 0xFFFF5678.
- Issue a read, assert srst_i on the next edge (RD_LATENCY=2) -> no rd_valid_o pulse, rd_data_o=0 after reset.
- RAM_BE_PIPE_CLEAR_EN, AWIDTH=4:
  - After reset release, ready_o=0 for 16 cycles, then 1.
  - Every address reads 0.
  - A write issued during the clear leaves addr 3 reading 0.
- RAM_BE_PIPE_CLEAR_EN: assert srst_i at clear cycle 8 -> ready_o returns 16 cycles after the second release.
